// File: rtl/bmem_arbiter_if.sv
// Bundle of the two cacheline requester ports and the burst memory port
// shared by bmem_arbiter. The arbiter connects through the slave modport;
// the requesters and the memory model connect through the master modport.
interface bmem_arbiter_if;
    // port 0: instruction cache dfp
    logic [31:0]  req0_addr;
    logic         req0_read;
    logic         req0_write;
    logic [255:0] req0_wdata;
    logic [255:0] req0_rdata;
    logic         req0_resp;

    // port 1: data cache dfp
    logic [31:0]  req1_addr;
    logic         req1_read;
    logic         req1_write;
    logic [255:0] req1_wdata;
    logic [255:0] req1_rdata;
    logic         req1_resp;

    // burst memory port
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    modport slave (
        input  req0_addr, req0_read, req0_write, req0_wdata,
        output req0_rdata, req0_resp,
        input  req1_addr, req1_read, req1_write, req1_wdata,
        output req1_rdata, req1_resp,
        output bmem_addr, bmem_read, bmem_write, bmem_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );

    modport master (
        output req0_addr, req0_read, req0_write, req0_wdata,
        input  req0_rdata, req0_resp,
        output req1_addr, req1_read, req1_write, req1_wdata,
        input  req1_rdata, req1_resp,
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );
endinterface

// File: rtl/bmem_arbiter.sv
// Two-port cacheline arbiter in front of the single burst memory port.
// Port 0 is the icache dfp, port 1 the dcache dfp. One full-line transfer
// is outstanding at a time: reads issue a one-cycle command and collect
// BURST_LEN 64-bit beats (low beat first); writes stream BURST_LEN beats.
// The granted port sees a one-cycle resp when the line is done.
module bmem_arbiter #(
    parameter int ROUND_ROBIN = 1,
    parameter int BURST_LEN   = 4
) (
    input  logic           clk,
    input  logic           rst,    // asynchronous, active low
    bmem_arbiter_if.slave  bus
);

    localparam int LINE_W = 64 * BURST_LEN;
    localparam int CNT_W  = 2;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_CMD,
        RD_WAIT,
        WR_BURST,
        DONE
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               last_grant_q;
    logic               port_q;
    logic [31:0]        addr_q;
    logic [LINE_W-1:0]  line_q;
    logic               rd_q;
    logic               wr_q;
    logic [63:0]        wdata_q;
    logic               resp0_q;
    logic               resp1_q;
    logic [LINE_W-1:0]  rdata0_q;
    logic [LINE_W-1:0]  rdata1_q;

    logic               req0;
    logic               req1;
    logic               grant_d;
    logic [31:0]        sel_addr;
    logic               sel_write;
    logic [LINE_W-1:0]  sel_wdata;
    logic               beat_match;
    logic [CNT_W-1:0]   cnt_inc;
    logic [LINE_W-1:0]  line_ins;
    logic [63:0]        next_beat;

    assign req0 = bus.req0_read | bus.req0_write;
    assign req1 = bus.req1_read | bus.req1_write;

    // Arbitration: a lone requester wins; on contention alternate away from
    // the last grant, or favour the dcache in fixed-priority mode.
    always_comb begin
        grant_d = 1'b0;
        if (req0 && req1) begin
            grant_d = (ROUND_ROBIN != 0) ? ~last_grant_q : 1'b1;
        end else if (req1) begin
            grant_d = 1'b1;
        end
    end

    // Request fields of the port being granted; write wins over read.
    always_comb begin
        if (grant_d) begin
            sel_addr  = bus.req1_addr;
            sel_write = bus.req1_write;
            sel_wdata = bus.req1_wdata;
        end else begin
            sel_addr  = bus.req0_addr;
            sel_write = bus.req0_write;
            sel_wdata = bus.req0_wdata;
        end
    end

    assign beat_match = bus.bmem_rvalid && (bus.bmem_raddr == addr_q);
    assign cnt_inc    = cnt_q + 1'b1;
    assign next_beat  = line_q[{cnt_inc, 6'b0} +: 64];

    // Line buffer with the incoming read beat dropped into its slot, so the
    // final beat can be forwarded to rdata in the same cycle it arrives.
    always_comb begin
        line_ins = line_q;
        line_ins[{cnt_q, 6'b0} +: 64] = bus.bmem_rdata;
    end

    // Transfer sequencer with registered memory and response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            port_q       <= 1'b0;
            addr_q       <= '0;
            line_q       <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            wdata_q      <= '0;
            resp0_q      <= 1'b0;
            resp1_q      <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            resp0_q <= 1'b0;
            resp1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        port_q       <= grant_d;
                        last_grant_q <= grant_d;
                        addr_q       <= sel_addr & ~32'h1f;
                        cnt_q        <= '0;
                        if (sel_write) begin
                            line_q  <= sel_wdata;
                            wdata_q <= sel_wdata[63:0];
                            wr_q    <= 1'b1;
                            state_q <= WR_BURST;
                        end else begin
                            rd_q    <= 1'b1;
                            state_q <= RD_CMD;
                        end
                    end
                end
                RD_CMD: begin
                    if (bus.bmem_ready) begin
                        rd_q    <= 1'b0;
                        state_q <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (beat_match) begin
                        line_q <= line_ins;
                        if (cnt_q == LAST_BEAT) begin
                            cnt_q   <= '0;
                            state_q <= DONE;
                            if (port_q) begin
                                resp1_q  <= 1'b1;
                                rdata1_q <= line_ins;
                            end else begin
                                resp0_q  <= 1'b1;
                                rdata0_q <= line_ins;
                            end
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                end
                WR_BURST: begin
                    if (bus.bmem_ready) begin
                        if (cnt_q == LAST_BEAT) begin
                            wr_q    <= 1'b0;
                            wdata_q <= '0;
                            cnt_q   <= '0;
                            state_q <= DONE;
                            if (port_q) begin
                                resp1_q <= 1'b1;
                            end else begin
                                resp0_q <= 1'b1;
                            end
                        end else begin
                            cnt_q   <= cnt_inc;
                            wdata_q <= next_beat;
                        end
                    end
                end
                DONE: begin
                    // resp is high this cycle; no grant here so a requester
                    // dropping on resp cannot be picked up again.
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.bmem_addr  = addr_q;
    assign bus.bmem_read  = rd_q;
    assign bus.bmem_write = wr_q;
    assign bus.bmem_wdata = wdata_q;
    assign bus.req0_resp  = resp0_q;
    assign bus.req1_resp  = resp1_q;
    assign bus.req0_rdata = rdata0_q;
    assign bus.req1_rdata = rdata1_q;

    // Only four-beat lines are implemented.
    a_burst_len: assert property (@(posedge clk) disable iff (!rst)
        BURST_LEN == 4);

    // Read and write together on one port is illegal (write is served).
    a_port0_rw: assert property (@(posedge clk) disable iff (!rst)
        !(bus.req0_read && bus.req0_write));
    a_port1_rw: assert property (@(posedge clk) disable iff (!rst)
        !(bus.req1_read && bus.req1_write));

    // Memory command and write beat never overlap.
    a_cmd_excl: assert property (@(posedge clk) disable iff (!rst)
        !(rd_q && wr_q));

endmodule

// File: tb/tb_bmem_arbiter.sv
// Directed bench for bmem_arbiter. A round-robin and a fixed-priority
// instance share the stimulus; 'sel' picks whose outputs are watched.
// Expected commands, write beats and responses are queued as stimulus is
// driven and checked by a monitor when the DUT produces them.
module tb_bmem_arbiter;

    logic clk;
    logic rst;
    logic sel;

    logic [31:0]  r0a, r1a;
    logic         r0r, r0w, r1r, r1w;
    logic [255:0] r0wd, r1wd;
    logic         rdy;
    logic [31:0]  raddr;
    logic [63:0]  rdat;
    logic         rvld;

    bmem_arbiter_if ifa ();
    bmem_arbiter_if ifb ();

    bmem_arbiter #(.ROUND_ROBIN(1), .BURST_LEN(4)) dut_rr (.clk(clk), .rst(rst), .bus(ifa));
    bmem_arbiter #(.ROUND_ROBIN(0), .BURST_LEN(4)) dut_fp (.clk(clk), .rst(rst), .bus(ifb));

    assign ifa.req0_addr = r0a;   assign ifb.req0_addr = r0a;
    assign ifa.req0_read = r0r;   assign ifb.req0_read = r0r;
    assign ifa.req0_write = r0w;  assign ifb.req0_write = r0w;
    assign ifa.req0_wdata = r0wd; assign ifb.req0_wdata = r0wd;
    assign ifa.req1_addr = r1a;   assign ifb.req1_addr = r1a;
    assign ifa.req1_read = r1r;   assign ifb.req1_read = r1r;
    assign ifa.req1_write = r1w;  assign ifb.req1_write = r1w;
    assign ifa.req1_wdata = r1wd; assign ifb.req1_wdata = r1wd;
    assign ifa.bmem_ready = rdy;  assign ifb.bmem_ready = rdy;
    assign ifa.bmem_raddr = raddr; assign ifb.bmem_raddr = raddr;
    assign ifa.bmem_rdata = rdat; assign ifb.bmem_rdata = rdat;
    assign ifa.bmem_rvalid = rvld; assign ifb.bmem_rvalid = rvld;

    logic [31:0]  m_addr;
    logic         m_read, m_write, m_resp0, m_resp1;
    logic [63:0]  m_wdata;
    logic [255:0] m_rdata0, m_rdata1;
    assign m_addr   = sel ? ifb.bmem_addr  : ifa.bmem_addr;
    assign m_read   = sel ? ifb.bmem_read  : ifa.bmem_read;
    assign m_write  = sel ? ifb.bmem_write : ifa.bmem_write;
    assign m_wdata  = sel ? ifb.bmem_wdata : ifa.bmem_wdata;
    assign m_resp0  = sel ? ifb.req0_resp  : ifa.req0_resp;
    assign m_resp1  = sel ? ifb.req1_resp  : ifa.req1_resp;
    assign m_rdata0 = sel ? ifb.req0_rdata : ifa.req0_rdata;
    assign m_rdata1 = sel ? ifb.req1_rdata : ifa.req1_rdata;

    typedef struct {
        bit           port;
        bit           rd;
        logic [255:0] line;
    } exp_t;

    exp_t         exp_resp[$];
    logic [31:0]  exp_cmd[$];
    logic [63:0]  exp_beat[$];

    int n_checks = 0;
    int n_fail   = 0;
    int rd_cycles, wr_cycles, resp_cnt0, resp_cnt1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] mkline(input logic [31:0] seed);
        logic [255:0] l;
        for (int j = 0; j < 4; j++) l[j*64 +: 64] = {seed, 32'(j + 1) * 32'h0101_0101};
        return l;
    endfunction

    // Monitor: checks outputs on the falling edge against the queues.
    always @(negedge clk) begin
        exp_t e;
        if (m_read) rd_cycles++;
        if (m_write) wr_cycles++;
        if (m_read && rdy) begin
            chk("cmd_pending", exp_cmd.size() != 0, 1);
            if (exp_cmd.size() != 0) chk("cmd_addr", m_addr, exp_cmd.pop_front());
        end
        if (m_write) begin
            chk("beat_pending", exp_beat.size() != 0, 1);
            if (exp_beat.size() != 0) begin
                if (rdy) chk("wbeat", m_wdata, exp_beat.pop_front());
                else     chk("wbeat_hold", m_wdata, exp_beat[0]);
            end
        end
        if (m_resp0 || m_resp1) begin
            if (m_resp0) resp_cnt0++;
            if (m_resp1) resp_cnt1++;
            chk("resp_pending", exp_resp.size() != 0, 1);
            chk("resp_single", m_resp0 & m_resp1, 0);
            if (exp_resp.size() != 0) begin
                e = exp_resp.pop_front();
                chk("resp_port", m_resp1, e.port);
                if (e.rd) chk("rdata", e.port ? m_rdata1 : m_rdata0, e.line);
            end
        end
    end

    // Wait for the read command, then return four beats (optionally with a
    // stray beat carrying a different address in the middle).
    task automatic serve_read(input logic [31:0] a, input logic [255:0] line, input bit stray);
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m_read && rdy) begin seen = 1; break; end
        end
        chk("cmd_seen", seen, 1);
        @(posedge clk); #1;
        for (int j = 0; j < 4; j++) begin
            if (stray && j == 2) begin
                rvld = 1'b1; raddr = a + 32'h20; rdat = 64'hdead_beef_dead_beef;
                step();
            end
            rvld = 1'b1; raddr = a; rdat = line[j*64 +: 64];
            step();
        end
        rvld = 1'b0; rdat = '0; raddr = '0;
    endtask

    task automatic wait_done(input bit port);
        bit found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((port ? m_resp1 : m_resp0) === 1'b1) begin found = 1; break; end
        end
        chk(port ? "done_p1" : "done_p0", found, 1);
    endtask

    task automatic push_read(input bit port, input logic [31:0] a, input logic [255:0] line);
        exp_t e;
        e.port = port; e.rd = 1'b1; e.line = line;
        exp_cmd.push_back(a & ~32'h1f);
        exp_resp.push_back(e);
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [255:0] l1, lw, ls, lr;
        exp_t e;
        rst = 1'b0; sel = 1'b0; rdy = 1'b1;
        r0a = '0; r1a = '0; r0r = 0; r0w = 0; r1r = 0; r1w = 0; r0wd = '0; r1wd = '0;
        raddr = '0; rdat = '0; rvld = 1'b0;
        rd_cycles = 0; wr_cycles = 0; resp_cnt0 = 0; resp_cnt1 = 0;

        // reset state
        #12;
        chk("rst_read", m_read, 0);
        chk("rst_write", m_write, 0);
        chk("rst_addr", m_addr, 0);
        chk("rst_wdata", m_wdata, 0);
        chk("rst_resp", {m_resp1, m_resp0}, 0);
        chk("rst_rdata0", m_rdata0, 0);
        chk("rst_rdata1", m_rdata1, 0);
        step();
        rst = 1'b1;
        step();

        // single read, port 0
        l1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        rd_cycles = 0;
        r0a = 32'h1eceb004; r0r = 1'b1;
        push_read(0, 32'h1eceb004, l1);
        serve_read(32'h1eceb000, l1, 0);
        wait_done(0);
        r0r = 1'b0;
        step();
        chk("t1_rd_cycles", rd_cycles, 1);
        chk("t1_q_empty", exp_resp.size() + exp_cmd.size(), 0);

        // single write, port 1, ready dropped during beat 1
        lw = {64'hdddd_0000_0000_000d, 64'hcccc_0000_0000_000c,
              64'hbbbb_0000_0000_000b, 64'haaaa_0000_0000_000a};
        for (int j = 0; j < 4; j++) exp_beat.push_back(lw[j*64 +: 64]);
        e.port = 1'b1; e.rd = 1'b0; e.line = '0;
        exp_resp.push_back(e);
        wr_cycles = 0; resp_cnt1 = 0;
        r1a = 32'h0000_2047; r1wd = lw; r1w = 1'b1;
        step();
        chk("t2_addr", m_addr, 32'h0000_2040);
        step();
        rdy = 1'b0;
        step(); step();
        rdy = 1'b1;
        wait_done(1);
        r1w = 1'b0;
        step(); step();
        chk("t2_wr_cycles", wr_cycles, 6);
        chk("t2_resp_cnt", resp_cnt1, 1);
        chk("t2_q_empty", exp_beat.size() + exp_resp.size(), 0);
        chk("t2_rdata0_hold", m_rdata0, l1);

        // read with a stray mismatched beat, port 1
        ls = mkline(32'h5151_0000);
        r1a = 32'h0000_3000; r1r = 1'b1;
        push_read(1, 32'h0000_3000, ls);
        serve_read(32'h0000_3000, ls, 1);
        wait_done(1);
        r1r = 1'b0;
        step();
        chk("t3_q_empty", exp_resp.size() + exp_cmd.size(), 0);

        // reset in the middle of a write burst
        lw = mkline(32'h7777_0000);
        for (int j = 0; j < 4; j++) exp_beat.push_back(lw[j*64 +: 64]);
        e.port = 1'b0; e.rd = 1'b0; e.line = '0;
        exp_resp.push_back(e);
        r0a = 32'h0000_4000; r0wd = lw; r0w = 1'b1;
        step(); step(); step(); step();
        rst = 1'b0;
        #1;
        chk("t4_write_off", m_write, 0);
        chk("t4_no_resp", {m_resp1, m_resp0}, 0);
        chk("t4_wdata_clr", m_wdata, 0);
        exp_beat.delete();
        exp_resp.delete();
        r0w = 1'b0;
        step(); step();
        rst = 1'b1;
        rvld = 1'b1; raddr = 32'h0000_4000; rdat = 64'h0bad_0bad_0bad_0bad;
        step(); step();
        rvld = 1'b0;
        step();
        chk("t4_rdata0_clr", m_rdata0, 0);
        lr = mkline(32'h5000_0000);
        r0a = 32'h0000_5000; r0r = 1'b1;
        push_read(0, 32'h0000_5000, lr);
        serve_read(32'h0000_5000, lr, 0);
        wait_done(0);
        r0r = 1'b0;
        step();
        chk("t4_q_empty", exp_resp.size() + exp_cmd.size(), 0);

        // contention, round robin: grants 0,1,0,1
        pulse_reset();
        resp_cnt0 = 0; resp_cnt1 = 0;
        r0a = 32'h0001_0000; r1a = 32'h0002_0000;
        r0r = 1'b1; r1r = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bit p;
            logic [31:0] a;
            p = k[0];
            a = p ? 32'h0002_0000 : 32'h0001_0000;
            lr = mkline(32'hc0de_0000 + 32'(k));
            push_read(p, a, lr);
            serve_read(a, lr, 0);
            wait_done(p);
        end
        r0r = 1'b0; r1r = 1'b0;
        step(); step();
        chk("t5_resp_cnt0", resp_cnt0, 2);
        chk("t5_resp_cnt1", resp_cnt1, 2);
        chk("t5_q_empty", exp_resp.size() + exp_cmd.size(), 0);

        // contention, fixed priority: port 1 first, port 0 after it drops
        sel = 1'b1;
        pulse_reset();
        r0a = 32'h0003_0000; r1a = 32'h0004_0000;
        r0r = 1'b1; r1r = 1'b1;
        lr = mkline(32'hf1f1_0001);
        push_read(1, 32'h0004_0000, lr);
        serve_read(32'h0004_0000, lr, 0);
        wait_done(1);
        r1r = 1'b0;
        lr = mkline(32'hf0f0_0000);
        push_read(0, 32'h0003_0000, lr);
        serve_read(32'h0003_0000, lr, 0);
        wait_done(0);
        r0r = 1'b0;
        step(); step();
        chk("t6_q_empty", exp_resp.size() + exp_cmd.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bmem_arbiter.md
Name: bmem_arbiter

Overview:
- Shares the single burst memory port (bmem_*) between two cacheline requesters: port 0 = instruction cache dfp, port 1 = data cache dfp.
- Sequences full-line transfers:
  - reads: one-cycle command, then 4 returned 64-bit beats assembled into a 256-bit line;
  - writes: 4 consecutive 64-bit beats.
- Replaces the direct cache-to-bmem hookup and the standalone cacheline adapter at the top level.

Parameters:
- ROUND_ROBIN, 1, 1 = alternate grant when both ports request; 0 = fixed priority to port 1 (dcache).
- BURST_LEN, 4, beats per line; line width = 64*BURST_LEN. Only 4 is supported; the parameter exists for assertion checks.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = in reset)
- req0_addr  in  32  port 0 line address; bits [4:0] ignored
- req0_read  in  1  port 0 read request, level, held until req0_resp
- req0_write  in  1  port 0 write request, level, held until req0_resp
- req0_wdata  in  256  port 0 write line, held with req0_write
- req0_rdata  out  256  port 0 read line, valid with req0_resp
- req0_resp  out  1  port 0 completion pulse, one cycle
- req1_addr, req1_read, req1_write, req1_wdata, req1_rdata, req1_resp: same as port 0, for port 1
- bmem_addr  out  32  memory line address, bits [4:0] = 0
- bmem_read  out  1  read command, one cycle per line
- bmem_write  out  1  write beat valid
- bmem_wdata  out  64  write beat data
- bmem_ready  in  1  memory accepts command/beat this cycle
- bmem_raddr  in  32  address tag of the returning read beat
- bmem_rdata  in  64  read beat data
- bmem_rvalid  in  1  read beat valid

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE, beat count = 0, last_grant = 1 (so port 0 wins first under round-robin);
  - all outputs 0, including req*_rdata and bmem_wdata.
- States: IDLE, RD_CMD, RD_WAIT, WR_BURST, DONE.
- IDLE:
  - Requesting port = read|write.
  - One requester: grant it.
  - Both: ROUND_ROBIN=1 grants the port not equal to last_grant; ROUND_ROBIN=0 grants port 1.
  - Latch addr (bits [4:0] zeroed), op, and wdata at grant.
  - Update last_grant.
  - Go to WR_BURST if write, else RD_CMD.
  - read and write both high on one port is illegal; write wins; flagged by assertion.
- RD_CMD:
  - bmem_read=1, bmem_addr = latched addr.
  - If bmem_ready, go to RD_WAIT next cycle; otherwise hold the command.
- RD_WAIT:
  - bmem_read=0.
  - Each cycle with bmem_rvalid=1 and bmem_raddr equal to the latched addr stores bmem_rdata into beat slot [count], low beat first (bits [63:0] first); count increments.
  - Beats with a mismatched raddr are ignored.
  - When beat 3 is stored, go to DONE.
- WR_BURST:
  - bmem_write=1, bmem_addr = latched addr, bmem_wdata = latched line beat [count], low beat first.
  - Count advances only on cycles with bmem_ready=1. With bmem_ready=0, the beat and bmem_write are held.
  - After beat 3 is accepted, go to DONE.
- DONE:
  - The granted port's resp=1 for exactly this cycle.
  - For reads, that port's rdata = assembled line. rdata holds its value until the next read completion on that port.
  - Count clears; next state is IDLE.
  - No grant is made in DONE, so a requester dropping its request combinationally on resp is never re-granted.
- Latency, uncontended read with bmem_ready=1:
  - grant cycle (IDLE) -> RD_CMD next cycle;
  - resp arrives 1 cycle after the 4th rvalid beat.
- Latency, uncontended write with ready=1:
  - resp 6 cycles after the request is first seen in IDLE: 1 grant + 4 beats + DONE.
- Exactly one transfer is outstanding at a time; the other port waits with its request held.
- Reset asserted mid-burst:
  - immediate return to IDLE;
  - no resp is issued for the aborted transfer;
  - stray rvalid beats after reset release are ignored, since there is no outstanding read.
- Requests are not sampled while rst=0.

Test Plan:
- Single read, port 0:
  - Stimulus: req0_read, addr 0x1eceb004, ready=1; beats 0x11..,0x22..,0x33..,0x44.. with raddr 0x1eceb000.
  - Required: bmem_addr 0x1eceb000; bmem_read high 1 cycle; req0_rdata = {0x44..,0x33..,0x22..,0x11..}; req0_resp high 1 cycle.
- Single write, port 1:
  - Stimulus: line with beats A,B,C,D; bmem_ready dropped for 2 cycles during beat 1.
  - Required: bmem_wdata sequence A,B(held 3 cycles),C,D; bmem_write high 6 cycles; req1_resp once.
- Contention, ROUND_ROBIN=1:
  - Stimulus: both ports request reads continuously for 4 transfers.
  - Required: grant order 0,1,0,1; each port gets 2 resp pulses.
- Contention, ROUND_ROBIN=0:
  - Stimulus: both ports request.
  - Required: port 1 is served first; port 0 is served after port 1 drops its request.
- Mismatched raddr:
  - Stimulus: stray rvalid beat with a different raddr during RD_WAIT.
  - Required: the stray beat is ignored; the line is assembled from the 4 matching beats only.
- Reset mid-write:
  - Stimulus: rst=0 after beat 2.
  - Required: bmem_write=0 immediately, no resp; after release, a new port-0 request completes normally.
